// File: rtl/dilithium_pkg.sv
// Shared Dilithium job definitions: mode encoding, security levels, per-operation output sizes.
// Used by the job controller and the output adapter so both agree on stream lengths.
package dilithium_pkg;

   typedef enum logic [1:0] {
      MODE_KEYGEN  = 2'd0,
      MODE_VERIFY  = 2'd1,
      MODE_SIGN    = 2'd2,
      MODE_ILLEGAL = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } job_state_e;

   localparam logic [2:0] SEC_LVL_2 = 3'd2;
   localparam logic [2:0] SEC_LVL_3 = 3'd3;
   localparam logic [2:0] SEC_LVL_5 = 3'd5;

   // Output sizes in 64-bit words.
   localparam logic [15:0] KEYGEN_WORDS_L2 = 16'd480;
   localparam logic [15:0] KEYGEN_WORDS_L3 = 16'd744;
   localparam logic [15:0] KEYGEN_WORDS_L5 = 16'd932;
   localparam logic [15:0] VERIFY_WORDS    = 16'd1;
   localparam logic [15:0] SIGN_WORDS_L2   = 16'd303;
   localparam logic [15:0] SIGN_WORDS_L3   = 16'd412;
   localparam logic [15:0] SIGN_WORDS_L5   = 16'd575;

   // Unknown levels run as the strongest parameter set.
   function automatic logic [2:0] normalize_sec_lvl(input logic [2:0] sec_lvl);
      if (sec_lvl == SEC_LVL_2 || sec_lvl == SEC_LVL_3) return sec_lvl;
      return SEC_LVL_5;
   endfunction

   function automatic logic [15:0] expected_out_words(input logic [1:0] mode,
                                                      input logic [2:0] sec_lvl);
      logic [15:0] words;
      words = '0;
      case (mode_e'(mode))
         MODE_KEYGEN: begin
            case (sec_lvl)
               SEC_LVL_2: words = KEYGEN_WORDS_L2;
               SEC_LVL_3: words = KEYGEN_WORDS_L3;
               default:   words = KEYGEN_WORDS_L5;
            endcase
         end
         MODE_VERIFY: words = VERIFY_WORDS;
         MODE_SIGN: begin
            case (sec_lvl)
               SEC_LVL_2: words = SIGN_WORDS_L2;
               SEC_LVL_3: words = SIGN_WORDS_L3;
               default:   words = SIGN_WORDS_L5;
            endcase
         end
         default: words = '0;
      endcase
      return words;
   endfunction

endpackage

// File: rtl/job_watchdog.sv
// Loadable down-counter: clear reloads TIMEOUT_CYCLES-1, expire is high while enabled at zero.
// Zero latency from count reaching zero to expire; no handshake, never stalls.
module job_watchdog #(
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expire
);

   localparam int W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LOAD_VAL = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= LOAD_VAL;
      end else if (clear) begin
         cnt <= LOAD_VAL;
      end else if (en && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign expire = en && (cnt == '0);

endmodule

// File: rtl/dilithium_job_controller.sv
// Runs one Dilithium job: start pulse in, counts adapter output beats, done/err out; cmd_ready only in IDLE.
// Optional watchdog under DILITHIUM_JOB_WATCHDOG_EN; beats are snooped, never backpressured.
module dilithium_job_controller
   import dilithium_pkg::*;
#(
   parameter int W_CNT          = 10,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_mode,
   input  logic [2:0] cmd_sec_lvl,
   output logic       start,
   output logic [1:0] mode,
   output logic [2:0] sec_lvl,
   input  logic       out_valid,
   input  logic       out_ready,
   input  logic       out_last,
   output logic       busy,
   output logic       done,
   output logic       err_size,
   output logic       err_cmd,
   output logic       err_timeout
);

   job_state_e       state, state_nxt;
   logic [W_CNT-1:0] beat_cnt;
   logic [W_CNT:0]   cnt_inc;
   logic [W_CNT:0]   exp_words;
   logic             accept;
   logic             beat;
   logic             wd_expire;

   assign accept    = cmd_valid && (state == ST_IDLE);
   assign beat      = out_valid && out_ready && (state == ST_RUN);
   assign cnt_inc   = {1'b0, beat_cnt} + (W_CNT+1)'(1);
   assign exp_words = (W_CNT+1)'(expected_out_words(mode, sec_lvl));

`ifdef DILITHIUM_JOB_WATCHDOG_EN
   logic err_timeout_q;

   job_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  ((state == ST_START) || beat),
      .en     (state == ST_RUN),
      .expire (wd_expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         err_timeout_q <= 1'b0;
      end else if (accept) begin
         err_timeout_q <= 1'b0;
      end else if (state == ST_RUN && wd_expire && !beat) begin
         err_timeout_q <= 1'b1;
      end
   end

   assign err_timeout = err_timeout_q;
`else
   assign wd_expire   = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_nxt = (cmd_mode == MODE_ILLEGAL) ? ST_DONE : ST_START;
            end
         end
         ST_START: state_nxt = ST_RUN;
         ST_RUN: begin
            if (beat && out_last) begin
               state_nxt = ST_DONE;
            end else if (wd_expire && !beat) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      start     = 1'b0;
      done      = 1'b0;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         ST_START: start = 1'b1;
         ST_DONE:  done  = 1'b1;
         default:  ;
      endcase
   end

   // Job registers, beat counter and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode     <= '0;
         sec_lvl  <= '0;
         beat_cnt <= '0;
         err_size <= 1'b0;
         err_cmd  <= 1'b0;
      end else if (accept) begin
         mode     <= cmd_mode;
         sec_lvl  <= normalize_sec_lvl(cmd_sec_lvl);
         beat_cnt <= '0;
         err_size <= 1'b0;
         err_cmd  <= (cmd_mode == MODE_ILLEGAL);
      end else if (beat) begin
         if (beat_cnt != '1) begin
            beat_cnt <= beat_cnt + 1'b1;
         end
         // A short stream is caught on last; an overlong one as soon as it reaches the size.
         if (out_last ? (cnt_inc != exp_words) : (cnt_inc >= exp_words)) begin
            err_size <= 1'b1;
         end
      end
   end

endmodule

// File: doc/dilithium_job_controller.md
# dilithium_job_controller

Sequences one Dilithium operation at a time through the core and its output adapter. It accepts a job command over a valid/ready handshake and drives a one-cycle `start` together with held `mode`/`sec_lvl` to the core and adapter. It then tracks the adapter's external output stream beat by beat, checks the beat count against the expected size for the operation, and reports completion or error to the host side.

## Interface
- `W_CNT`, default 10: width of the output-beat counter (must hold 932).
- `TIMEOUT_CYCLES`, default 65535: watchdog limit in cycles. Used only when the watchdog is compiled in.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  host presents a job.
- `cmd_ready`  out  1  controller can accept a job.
- `cmd_mode`  in  2  0=keygen, 1=verify, 2=sign, 3=illegal.
- `cmd_sec_lvl`  in  3  2, 3 or 5; any other value is treated as 5.
- `start`  out  1  one-cycle pulse to core and adapter.
- `mode`  out  2  registered job mode, held for the whole job.
- `sec_lvl`  out  3  registered security level, held for the whole job.
- `out_valid`, `out_ready`, `out_last`  in  1 each  snooped adapter output handshake.
- `busy`  out  1  a job is in progress.
- `done`  out  1  one-cycle completion pulse.
- `err_size`  out  1  sticky: beat count differed from the expected size.
- `err_cmd`  out  1  sticky: the last command was illegal.
- `err_timeout`  out  1  sticky: watchdog abort (constant 0 when the watchdog is compiled out).

## Operation
- States: IDLE, START, RUN, DONE.
- IDLE
  - `cmd_ready`=1.
  - On `cmd_valid`, latch `mode`/`sec_lvl` and clear all `err_*` flags and the beat counter.
  - Mode 3: set `err_cmd`, go to DONE; no `start` is issued.
  - Otherwise go to START.
- START: `start`=1 for exactly this cycle, then go to RUN.
- RUN
  - A beat is `out_valid && out_ready`; each beat increments the counter.
  - Expected size in 64-bit words:
    - mode 0: 480 / 744 / 932 for sec_lvl 2 / 3 / 5.
    - mode 1: 1.
    - mode 2: 303 / 412 / 575 for sec_lvl 2 / 3 / 5.
  - On a beat with `out_last`=1: if counter+1 ≠ expected, set `err_size`. Go to DONE.
  - On a beat with `out_last`=0 and counter+1 ≥ expected: set `err_size` and stay in RUN until `last` arrives.
  - The counter saturates at all-ones; it never wraps.
- DONE: `done`=1 for one cycle, then go to IDLE. `err_*` flags hold until the next command is accepted.
- `busy` = (state ≠ IDLE).
- Arithmetic is unsigned, `W_CNT` bits. The expected-size compare uses counter+1 evaluated at `W_CNT`+1 bits.

## Timing
- Reset values:
  - state IDLE; `cmd_ready`=1.
  - `start`=0, `done`=0, `busy`=0.
  - `mode`=0, `sec_lvl`=0.
  - all `err_*`=0; counter 0.
- Command accepted at edge N → `start`=1 during cycle N+1 → RUN from N+2.
- `last` beat accepted at edge M → `done`=1 during cycle M+1 → `cmd_ready`=1 from M+2.
- Illegal command accepted at edge N → `done`=1 and `err_cmd`=1 during cycle N+1.
- Beats seen outside RUN are ignored. `out_valid` without `out_ready` is not a beat.
- `rst` asserted mid-job returns to IDLE at the next edge with no `done` pulse.

## Configuration
- `DILITHIUM_JOB_WATCHDOG_EN` defined:
  - In RUN, a cycle counter resets on every beat and on RUN entry.
  - When it reaches `TIMEOUT_CYCLES` with no beat, set `err_timeout` and go to DONE.
- Undefined: no counter is instantiated, `err_timeout` is tied to 0, and RUN waits indefinitely.

## Structure
- Shared package `dilithium_pkg` holds:
  - the mode enum (KEYGEN=0, VERIFY=1, SIGN=2);
  - the security-level constants;
  - the per-mode/per-level output-size constants;
  - the function `expected_out_words(mode, sec_lvl)`. The adapter reuses this function.
- One sub-module, `job_watchdog`: a loadable down-counter with clear and expire outputs. It is instantiated only under the macro.

## Test plan
- Keygen, sec_lvl 2, adapter emits 480 beats with `last` on beat 480 → one `start` pulse; `done` one cycle after the last beat; `err_size`=0.
- Verify, 1 beat with `last` and `out_ready` stalled 5 cycles first → no beat is counted during the stall; `done` follows the beat; no error.
- Sign, sec_lvl 5, `last` on beat 574 → `err_size`=1 with `done`; the flag clears when the next command is accepted.
- `cmd_mode`=3 → `err_cmd`=1 and `done` in the cycle after acceptance; `start` never asserted.
- `rst` asserted at beat 100 of keygen sec_lvl 3 → next cycle IDLE, `busy`=0, no `done`; a new job then runs cleanly.
- Watchdog build with `TIMEOUT_CYCLES`=16, no beats after `start` → `err_timeout`=1 and `done` after 16 RUN cycles. Non-watchdog build: still `busy` after 1000 cycles.
